// File: rtl/mem_dr_responder_pkg.sv
// Shared types for the directory-to-memory responder: field widths, pending/ACK payloads.
// The data-ACK encoding and the byte-merge helper live here so benches can reuse them.
package mem_dr_responder_pkg;

  localparam int DRID_W       = 6;
  localparam int NID_W        = 5;
  localparam int CMD_W        = 4;
  localparam int PADDR_W      = 50;
  localparam int SNACK_W      = 3;
  localparam int SC_LINEBYTES = 64;
  localparam int LINE_W       = SC_LINEBYTES * 8;
  localparam int CHUNKS       = 8;
  localparam int CHUNK_W      = LINE_W / CHUNKS;

  typedef logic [DRID_W-1:0]       DR_reqid_type;
  typedef logic [NID_W-1:0]        SC_nodeid_type;
  typedef logic [CMD_W-1:0]        SC_cmd_type;
  typedef logic [PADDR_W-1:0]      SC_paddr_type;
  typedef logic [SNACK_W-1:0]      SC_snack_type;
  typedef logic [LINE_W-1:0]       SC_line_type;
  typedef logic [SC_LINEBYTES-1:0] SC_disp_mask_type;

  localparam SC_snack_type MEMR_ACK_CODE = 3'b100;

  typedef struct packed {
    DR_reqid_type  drid;
    SC_nodeid_type nid;
    SC_paddr_type  paddr;
    SC_line_type   line;
  } MEMR_pend_type;

  typedef struct packed {
    DR_reqid_type  drid;
    SC_nodeid_type nid;
    SC_paddr_type  paddr;
    SC_snack_type  ack;
    SC_line_type   line;
  } MEMR_ack_type;

  function automatic SC_line_type merge_line(SC_line_type old_line, SC_line_type new_line,
                                             SC_disp_mask_type mask);
    SC_line_type r;
    r = old_line;
    for (int i = 0; i < SC_LINEBYTES; i++) begin
      if (mask[i]) r[i*8 +: 8] = new_line[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/fflop.sv
// Single-entry valid/retry pipeline register; 1-cycle latency.
// Holds its contents while downstream retries; upstream sees retry only when full and stalled.
module fflop #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_din_valid,
  output logic         o_din_retry,
  input  logic [W-1:0] i_din,
  output logic         o_q_valid,
  input  logic         i_q_retry,
  output logic [W-1:0] o_q
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  assign o_din_retry = r_valid & i_q_retry;
  assign w_load      = i_din_valid & ~o_din_retry;
  assign o_q_valid   = r_valid;
  assign o_q         = r_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= i_din;
    end else if (!i_q_retry) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_pend_fifo.sv
// In-order pending-read FIFO; each entry counts down from LATENCY-1 and is poppable at zero.
// Full/empty are registered, so a push is refused while full even if a pop happens that cycle.
module mem_pend_fifo #(
  parameter int PEND    = 4,
  parameter int LATENCY = 4,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic         o_head_rdy,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(PEND);
  localparam int NW = AW + 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [NW-1:0] NUM_FULL = NW'(PEND);

  logic [W-1:0]  r_dat [PEND];
  logic [CW-1:0] r_cnt [PEND];
  logic [PEND-1:0] r_vld;
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [NW-1:0] r_num;
  logic          r_full;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [NW-1:0] w_num_nxt;

  assign w_push     = i_push & ~r_full;
  assign w_pop      = i_pop & o_head_rdy;
  assign w_num_nxt  = r_num + NW'(w_push) - NW'(w_pop);
  assign o_head_dat = r_dat[r_rp];
  assign o_head_rdy = r_vld[r_rp] & (r_cnt[r_rp] == '0);
  assign o_full     = r_full;
  assign o_empty    = r_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_dat[r_wp] <= i_push_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_num   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      for (int i = 0; i < PEND; i++) r_cnt[i] <= '0;
    end else begin
      // Every live entry ages in parallel so back-to-back accepts drain back-to-back.
      for (int i = 0; i < PEND; i++) begin
        if (w_push && r_wp == AW'(i)) begin
          r_cnt[i] <= CNT_INIT;
          r_vld[i] <= 1'b1;
        end else begin
          if (r_vld[i] && r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - CW'(1);
          if (w_pop && r_rp == AW'(i)) r_vld[i] <= 1'b0;
        end
      end
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_num   <= w_num_nxt;
      r_full  <= (w_num_nxt == NUM_FULL);
      r_empty <= (w_num_nxt == '0);
    end
  end

endmodule

// File: rtl/mem_dr_responder.sv
// Directory-side memory model: byte-merging backing store, reads/prefetches ACKed in order
// LATENCY+1 cycles after accept at the earliest; ACK stage holds under memtodr_ack_retry.
module mem_dr_responder
  import mem_dr_responder_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int PEND    = 4,
  parameter int NLINES  = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    drtomem_req_valid,
  output logic                    drtomem_req_retry,
  input  logic [DRID_W-1:0]       drtomem_req_drid,
  input  logic [CMD_W-1:0]        drtomem_req_cmd,
  input  logic [PADDR_W-1:0]      drtomem_req_paddr,
  input  logic                    drtomem_wb_valid,
  output logic                    drtomem_wb_retry,
  input  logic [LINE_W-1:0]       drtomem_wb_line,
  input  logic [SC_LINEBYTES-1:0] drtomem_wb_mask,
  input  logic [PADDR_W-1:0]      drtomem_wb_paddr,
  input  logic                    drtomem_pfreq_valid,
  output logic                    drtomem_pfreq_retry,
  input  logic [NID_W-1:0]        drtomem_pfreq_nid,
  input  logic [PADDR_W-1:0]      drtomem_pfreq_paddr,
  output logic                    memtodr_ack_valid,
  input  logic                    memtodr_ack_retry,
  output logic [DRID_W-1:0]       memtodr_ack_drid,
  output logic [NID_W-1:0]        memtodr_ack_nid,
  output logic [PADDR_W-1:0]      memtodr_ack_paddr,
  output logic [SNACK_W-1:0]      memtodr_ack_ack,
  output logic [CHUNK_W-1:0]      memtodr_ack_line_7,
  output logic [CHUNK_W-1:0]      memtodr_ack_line_6,
  output logic [CHUNK_W-1:0]      memtodr_ack_line_5,
  output logic [CHUNK_W-1:0]      memtodr_ack_line_4,
  output logic [CHUNK_W-1:0]      memtodr_ack_line_3,
  output logic [CHUNK_W-1:0]      memtodr_ack_line_2,
  output logic [CHUNK_W-1:0]      memtodr_ack_line_1,
  output logic [CHUNK_W-1:0]      memtodr_ack_line_0
);

  localparam int IW    = $clog2(NLINES);
  localparam int PW    = $bits(MEMR_pend_type);
  localparam int ACK_W = $bits(MEMR_ack_type);

  SC_line_type   r_store [NLINES];

  logic          w_wb_acc;
  logic          w_req_acc;
  logic          w_pf_acc;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_head_rdy;
  logic          w_ack_in_retry;
  logic [IW-1:0] w_wb_idx;
  logic [IW-1:0] w_rd_idx;
  SC_paddr_type  w_rd_paddr;
  MEMR_pend_type w_push_dat;
  MEMR_pend_type w_head_dat;
  MEMR_ack_type  w_ack_din;
  MEMR_ack_type  w_ack_q;
  logic          w_unused;

  // Writebacks always win the single store port; reads yield to them, prefetches to both.
  assign drtomem_wb_retry    = reset;
  assign drtomem_req_retry   = reset | drtomem_wb_valid | w_fifo_full;
  assign drtomem_pfreq_retry = reset | drtomem_wb_valid | drtomem_req_valid | w_fifo_full;

  assign w_wb_acc  = drtomem_wb_valid & ~drtomem_wb_retry;
  assign w_req_acc = drtomem_req_valid & ~drtomem_req_retry;
  assign w_pf_acc  = drtomem_pfreq_valid & ~drtomem_pfreq_retry;
  assign w_push    = w_req_acc | w_pf_acc;

  assign w_wb_idx   = drtomem_wb_paddr[IW+5:6];
  assign w_rd_paddr = w_req_acc ? drtomem_req_paddr : drtomem_pfreq_paddr;
  assign w_rd_idx   = w_rd_paddr[IW+5:6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NLINES; i++) r_store[i] <= '0;
    end else if (w_wb_acc) begin
      r_store[w_wb_idx] <= merge_line(r_store[w_wb_idx], drtomem_wb_line, drtomem_wb_mask);
    end
  end

  always_comb begin
    w_push_dat       = '0;
    w_push_dat.paddr = w_rd_paddr;
    w_push_dat.drid  = w_req_acc ? drtomem_req_drid : '0;
    w_push_dat.nid   = w_req_acc ? '0 : drtomem_pfreq_nid;
    w_push_dat.line  = r_store[w_rd_idx];
  end

  mem_pend_fifo #(
    .PEND    (PEND),
    .LATENCY (LATENCY),
    .W       (PW)
  ) u_pend_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head_dat),
    .o_head_rdy (w_head_rdy),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  assign w_pop = w_head_rdy & ~w_ack_in_retry;

  always_comb begin
    w_ack_din       = '0;
    w_ack_din.drid  = w_head_dat.drid;
    w_ack_din.nid   = w_head_dat.nid;
    w_ack_din.paddr = w_head_dat.paddr;
    w_ack_din.ack   = MEMR_ACK_CODE;
    w_ack_din.line  = w_head_dat.line;
  end

  fflop #(
    .W (ACK_W)
  ) u_ack_ff (
    .clk         (clk),
    .reset       (reset),
    .i_din_valid (w_head_rdy),
    .o_din_retry (w_ack_in_retry),
    .i_din       (w_ack_din),
    .o_q_valid   (memtodr_ack_valid),
    .i_q_retry   (memtodr_ack_retry),
    .o_q         (w_ack_q)
  );

  assign memtodr_ack_drid   = w_ack_q.drid;
  assign memtodr_ack_nid    = w_ack_q.nid;
  assign memtodr_ack_paddr  = w_ack_q.paddr;
  assign memtodr_ack_ack    = w_ack_q.ack;
  assign memtodr_ack_line_0 = w_ack_q.line[0*CHUNK_W +: CHUNK_W];
  assign memtodr_ack_line_1 = w_ack_q.line[1*CHUNK_W +: CHUNK_W];
  assign memtodr_ack_line_2 = w_ack_q.line[2*CHUNK_W +: CHUNK_W];
  assign memtodr_ack_line_3 = w_ack_q.line[3*CHUNK_W +: CHUNK_W];
  assign memtodr_ack_line_4 = w_ack_q.line[4*CHUNK_W +: CHUNK_W];
  assign memtodr_ack_line_5 = w_ack_q.line[5*CHUNK_W +: CHUNK_W];
  assign memtodr_ack_line_6 = w_ack_q.line[6*CHUNK_W +: CHUNK_W];
  assign memtodr_ack_line_7 = w_ack_q.line[7*CHUNK_W +: CHUNK_W];

  // cmd is not decoded and high wb address bits alias onto the store index.
  assign w_unused = ^{drtomem_req_cmd, w_fifo_empty, drtomem_wb_paddr};

endmodule

// File: tb/tb_mem_dr_responder.sv
// Scoreboard bench for mem_dr_responder: a byte-merge store model predicts every ACK in order.
module tb_mem_dr_responder;
  import mem_dr_responder_pkg::*;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                    req_valid, req_retry, wb_valid, wb_retry, pf_valid, pf_retry;
  logic [DRID_W-1:0]       req_drid;
  logic [CMD_W-1:0]        req_cmd;
  logic [PADDR_W-1:0]      req_paddr, wb_paddr, pf_paddr;
  logic [LINE_W-1:0]       wb_line;
  logic [SC_LINEBYTES-1:0] wb_mask;
  logic [NID_W-1:0]        pf_nid;
  logic                    ack_valid, ack_retry;
  logic [DRID_W-1:0]       ack_drid;
  logic [NID_W-1:0]        ack_nid;
  logic [PADDR_W-1:0]      ack_paddr;
  logic [SNACK_W-1:0]      ack_ack;
  logic [CHUNK_W-1:0]      l7, l6, l5, l4, l3, l2, l1, l0;

  mem_dr_responder #(.LATENCY(LAT), .PEND(4), .NLINES(64)) dut (
    .clk(clk), .reset(reset),
    .drtomem_req_valid(req_valid), .drtomem_req_retry(req_retry),
    .drtomem_req_drid(req_drid), .drtomem_req_cmd(req_cmd), .drtomem_req_paddr(req_paddr),
    .drtomem_wb_valid(wb_valid), .drtomem_wb_retry(wb_retry),
    .drtomem_wb_line(wb_line), .drtomem_wb_mask(wb_mask), .drtomem_wb_paddr(wb_paddr),
    .drtomem_pfreq_valid(pf_valid), .drtomem_pfreq_retry(pf_retry),
    .drtomem_pfreq_nid(pf_nid), .drtomem_pfreq_paddr(pf_paddr),
    .memtodr_ack_valid(ack_valid), .memtodr_ack_retry(ack_retry),
    .memtodr_ack_drid(ack_drid), .memtodr_ack_nid(ack_nid),
    .memtodr_ack_paddr(ack_paddr), .memtodr_ack_ack(ack_ack),
    .memtodr_ack_line_7(l7), .memtodr_ack_line_6(l6), .memtodr_ack_line_5(l5),
    .memtodr_ack_line_4(l4), .memtodr_ack_line_3(l3), .memtodr_ack_line_2(l2),
    .memtodr_ack_line_1(l1), .memtodr_ack_line_0(l0)
  );

  typedef struct {
    logic [DRID_W-1:0]  drid;
    logic [NID_W-1:0]   nid;
    logic [PADDR_W-1:0] paddr;
    logic [LINE_W-1:0]  line;
    int                 cyc;
    bit                 lat;
  } exp_t;

  exp_t              sb[$];
  exp_t              e;
  logic [LINE_W-1:0] mdl [64];
  int                ack_cyc[$];
  int                cyc = 0;
  int                n_chk = 0;
  int                n_pass = 0;
  int                n_ack = 0;
  bit                lat_chk = 1'b0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int lidx(input logic [PADDR_W-1:0] a);
    return int'(a[11:6]);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      for (int i = 0; i < 64; i++) mdl[i] = '0;
    end else begin
      if (wb_valid && !wb_retry)
        for (int b = 0; b < SC_LINEBYTES; b++)
          if (wb_mask[b]) mdl[lidx(wb_paddr)][b*8 +: 8] = wb_line[b*8 +: 8];
      if (req_valid && !req_retry) begin
        e.drid = req_drid; e.nid = '0; e.paddr = req_paddr;
        e.line = mdl[lidx(req_paddr)]; e.cyc = cyc; e.lat = lat_chk;
        sb.push_back(e);
      end
      if (pf_valid && !pf_retry) begin
        e.drid = '0; e.nid = pf_nid; e.paddr = pf_paddr;
        e.line = mdl[lidx(pf_paddr)]; e.cyc = cyc; e.lat = lat_chk;
        sb.push_back(e);
      end
      if (ack_valid && !ack_retry) begin
        n_ack++;
        ack_cyc.push_back(cyc);
        chk("ack_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("ack_drid", ack_drid, e.drid);
          chk("ack_nid", ack_nid, e.nid);
          chk("ack_paddr", ack_paddr, e.paddr);
          chk("ack_code", ack_ack, MEMR_ACK_CODE);
          chk("ack_line", {l7, l6, l5, l4, l3, l2, l1, l0}, e.line);
          if (e.lat) chk("ack_latency", cyc - e.cyc, LAT + 1);
        end
      end
    end
  end

  task automatic clr_in();
    req_valid = 1'b0; wb_valid = 1'b0; pf_valid = 1'b0;
  endtask

  task automatic send_wb(input logic [PADDR_W-1:0] a, input logic [LINE_W-1:0] l,
                         input logic [SC_LINEBYTES-1:0] m);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    clr_in();
    wb_valid = 1'b1; wb_paddr = a; wb_line = l; wb_mask = m;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!wb_retry) begin acc = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("wb_accept", acc, 1'b1);
  endtask

  task automatic send_req(input logic [DRID_W-1:0] id, input logic [PADDR_W-1:0] a, output bit saw);
    bit acc;
    acc = 1'b0; saw = 1'b0;
    @(posedge clk); #1;
    clr_in();
    req_valid = 1'b1; req_drid = id; req_paddr = a; req_cmd = 4'h3;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!req_retry) begin acc = 1'b1; break; end
      saw = 1'b1;
      @(posedge clk); #1;
    end
    chk("req_accept", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    clr_in();
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw, saw1, saw5;
    int base;
    reset = 1'b0; ack_retry = 1'b0;
    req_drid = '0; req_cmd = '0; req_paddr = '0; wb_paddr = '0; wb_line = '0; wb_mask = '0;
    pf_nid = '0; pf_paddr = '0;
    clr_in();
    #2 reset = 1'b1;

    repeat (3) begin
      @(negedge clk);
      chk("rst_retries", {wb_retry, req_retry, pf_retry}, 3'b111);
      chk("rst_ack_vld", ack_valid, 1'b0);
      chk("rst_ack_drid", ack_drid, '0);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_retries", {wb_retry, req_retry, pf_retry}, 3'b000);

    lat_chk = 1'b1;
    send_wb(50'h1040, {SC_LINEBYTES{8'hA5}}, '1);
    send_req(6'd3, 50'h1040, saw);
    idle(1);
    wait_drain(30);

    send_wb(50'h1040, {SC_LINEBYTES{8'h11}}, 64'hFF);
    send_req(6'd5, 50'h1040, saw);
    idle(1);
    wait_drain(30);

    @(posedge clk); #1;
    clr_in();
    wb_valid = 1'b1; wb_paddr = 50'h2000; wb_line = {SC_LINEBYTES{8'h3C}}; wb_mask = '1;
    req_valid = 1'b1; req_drid = 6'd6; req_paddr = 50'h2000;
    @(negedge clk); chk("req_retry_vs_wb", req_retry, 1'b1);
    @(posedge clk); #1 wb_valid = 1'b0;
    @(negedge clk); chk("req_retry_free", req_retry, 1'b0);
    @(posedge clk); #1;
    req_drid = 6'd7; pf_valid = 1'b1; pf_nid = 5'd2; pf_paddr = 50'h3000;
    @(negedge clk); chk("pf_retry_vs_req", pf_retry, 1'b1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); chk("pf_retry_free", pf_retry, 1'b0);
    idle(1);
    wait_drain(30);

    lat_chk = 1'b0;
    ack_retry = 1'b1;
    send_req(6'd1, 50'h1040, saw1);
    for (int d = 2; d <= 4; d++) send_req(DRID_W'(d), 50'h1040, saw);
    send_req(6'd5, 50'h1040, saw5);
    chk("bp_first_no_retry", saw1, 1'b0);
    chk("bp_fifth_retry", saw5, 1'b1);
    idle(10);
    ack_cyc.delete();
    ack_retry = 1'b0;
    wait_drain(40);
    chk("bp_ack_count", ack_cyc.size(), 5);
    for (int i = 0; i + 1 < ack_cyc.size(); i++)
      chk("bp_consecutive", ack_cyc[i+1] - ack_cyc[i], 1);

    ack_retry = 1'b1;
    for (int d = 10; d <= 13; d++) send_req(DRID_W'(d), 50'h1040, saw);
    idle(0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack_valid) break;
    end
    chk("mid_ack_presented", ack_valid, 1'b1);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("mid_rst_ack_drop", ack_valid, 1'b0);
    chk("mid_rst_req_retry", req_retry, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; ack_retry = 1'b0;
    base = n_ack;
    repeat (20) @(posedge clk);
    chk("no_replay", n_ack - base, 0);
    chk("sb_cleared", sb.size(), 0);

    lat_chk = 1'b1;
    send_req(6'd9, 50'h1040, saw);
    idle(1);
    wait_drain(30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
